// File: rtl/data_mem_port.sv
// Word-addressed data memory with a fixed multi-cycle access latency and a
// combinational busy stall toward the controller.
module data_mem_port #(
  parameter int NBITS   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             misaligned
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M2 = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW+1:0]     addr_q;
  logic [NBITS-1:0]  wdata_q;
  logic              wr_q;
  logic [NBITS-1:0]  rdata_q;
  logic              mis_q;
  logic [NBITS-1:0]  mem_q [DEPTH];

  logic              req, commit;
  logic [IW+1:0]     c_addr;
  logic [NBITS-1:0]  c_wdata;
  logic              c_wr;
  logic              unused_addr_hi;

  assign req            = MemRead | MemWrite;
  assign unused_addr_hi = ^addr[NBITS-1:IW+2];
  assign rdata          = rdata_q;
  assign misaligned     = mis_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        busy = 1'b1;
        if (LATENCY == 1) begin
          state_d = DONE;
        end else begin
          cnt_d   = LAT_M2;
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is also the capture edge, so use live inputs.
  always_comb begin
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_wr    = wr_q;
    if (state_q == IDLE) begin
      c_addr  = addr[IW+1:0];
      c_wdata = wdata;
      c_wr    = MemWrite;
    end
  end

  assign commit = (state_d == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= addr[IW+1:0];
        wdata_q <= wdata;
        wr_q    <= MemWrite;
      end
      mis_q <= commit && (c_addr[1:0] != 2'd0);
      if (commit && !c_wr) rdata_q <= mem_q[c_addr[IW+1:2]];
    end
  end

  // Contents survive reset; an aborted write never reaches the array.
  always_ff @(posedge clock) begin
    if (!reset && commit && c_wr) mem_q[c_addr[IW+1:2]] <= c_wdata;
  end
endmodule
